snake_input_conditioner: RTL and testbench

- Front end for the snake game's movement controller.
- Turns four raw, bouncing, asynchronous push-buttons into clean one-hot direction requests.
- Generates the single-cycle game tick that paces snake movement.
- Rejects 180-degree reversals and holds each request until the next tick, so a short press between ticks is never lost by the slow movement logic.

---
 rtl/snake_pkg.sv | 27 ++
 rtl/btn_debounce.sv | 64 ++++++
 rtl/snake_input_conditioner.sv | 141 ++++++++++++++
 tb/tb_snake_input_conditioner.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/snake_pkg.sv
// -----------------------------------------------------------------------------
// snake_pkg
// Types and helpers shared by the snake game input front end.
//   dir_t        : 2-bit movement direction (00 right, 01 left, 10 up, 11 down)
//   reverse_dir  : returns the 180-degree opposite of a direction
// -----------------------------------------------------------------------------
package snake_pkg;

    typedef enum logic [1:0] {
        DIR_RIGHT = 2'b00,
        DIR_LEFT  = 2'b01,
        DIR_UP    = 2'b10,
        DIR_DOWN  = 2'b11
    } dir_t;

    function automatic dir_t reverse_dir(input dir_t d);
        dir_t r;
        case (d)
            DIR_RIGHT: r = DIR_LEFT;
            DIR_LEFT:  r = DIR_RIGHT;
            DIR_UP:    r = DIR_DOWN;
            default:   r = DIR_UP;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// -----------------------------------------------------------------------------
// btn_debounce
// Conditions one raw asynchronous push-button: 2-FF synchronizer, stability
// counter and a one-cycle press pulse on the accepted rising edge.
//
// Ports:
//   clk      in   system clock
//   rst      in   asynchronous active-high reset
//   btn_i    in   raw button level, asynchronous to clk
//   press_o  out  one-clk pulse, high in the cycle whose closing edge flips
//                 the debounced level from 0 to 1
// -----------------------------------------------------------------------------
module btn_debounce
    import snake_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned CNT_W           = 24
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_i,
    output logic press_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             meta_q;
    logic             sync_q;
    logic             level_q, level_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // The counter only runs while the synced input disagrees with the
    // accepted level; any agreement (a bounce back) clears it.  The press
    // pulse is decoded combinationally from the flipping condition so the
    // consumer can latch the request on the very edge the level flips.
    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        press_o = 1'b0;
        if (sync_q != level_q) begin
            if (cnt_q == CNT_MAX) begin
                level_d = ~level_q;
                press_o = sync_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q  <= 1'b0;
            sync_q  <= 1'b0;
            level_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            meta_q  <= btn_i;
            sync_q  <= meta_q;
            level_q <= level_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: rtl/snake_input_conditioner.sv
// -----------------------------------------------------------------------------
// snake_input_conditioner
// Front end of the snake movement controller: debounces four direction
// buttons, generates the game tick, filters 180-degree reversals and holds
// the latest accepted request until the next tick commits it to dir.
//
// Optional build macro SNAKE_PAUSE_EN adds a pause button that toggles a
// paused state which freezes the tick counter and ignores direction presses.
//
// Ports:
//   clk, rst                   clock, asynchronous active-high reset
//   btn_up/down/left/right     raw buttons, asynchronous to clk
//   btn_pause  (SNAKE_PAUSE_EN) raw pause button
//   tick                       one-clk pulse every TICK_DIV cycles
//   up/down/left/right         pending request, one-hot (or all zero)
//   paused     (SNAKE_PAUSE_EN) current pause state
//   dir                        committed direction (snake_pkg::dir_t coding)
// -----------------------------------------------------------------------------
module snake_input_conditioner
    import snake_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned TICK_DIV        = 10000000,
    parameter int unsigned CNT_W           = 24
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_left,
    input  logic       btn_right,
`ifdef SNAKE_PAUSE_EN
    input  logic       btn_pause,
    output logic       paused,
`endif
    output logic       tick,
    output logic       up,
    output logic       down,
    output logic       left,
    output logic       right,
    output logic [1:0] dir
);

    localparam logic [CNT_W-1:0] TICK_MAX = CNT_W'(TICK_DIV - 1);

    // press[] and req_q[] are indexed by the dir_t encoding
    logic [3:0]       press;
    logic [3:0]       req_q, req_d;
    logic [3:0]       rev_mask;
    logic [3:0]       acc;
    dir_t             dir_q, dir_d;
    logic [CNT_W-1:0] tick_cnt_q, tick_cnt_d;
    logic             run;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_db_right (
        .clk(clk), .rst(rst), .btn_i(btn_right), .press_o(press[0])
    );
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_db_left (
        .clk(clk), .rst(rst), .btn_i(btn_left), .press_o(press[1])
    );
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_db_up (
        .clk(clk), .rst(rst), .btn_i(btn_up), .press_o(press[2])
    );
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_db_down (
        .clk(clk), .rst(rst), .btn_i(btn_down), .press_o(press[3])
    );

`ifdef SNAKE_PAUSE_EN
    logic pause_press;
    logic paused_q;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_db_pause (
        .clk(clk), .rst(rst), .btn_i(btn_pause), .press_o(pause_press)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            paused_q <= 1'b0;
        end else begin
            paused_q <= paused_q ^ pause_press;
        end
    end

    assign run    = ~paused_q;
    assign paused = paused_q;
`else
    assign run = 1'b1;
`endif

    assign tick = run && (tick_cnt_q == TICK_MAX);

    always_comb begin
        tick_cnt_d = tick_cnt_q;
        if (run) begin
            tick_cnt_d = (tick_cnt_q == TICK_MAX) ? '0 : tick_cnt_q + CNT_W'(1);
        end
    end

    // Commit first, then let a same-cycle press overwrite the cleared
    // request: the press is filtered against the direction in force before
    // this tick, and the latest accepted press always wins.
    always_comb begin
        rev_mask                        = '0;
        rev_mask[reverse_dir(dir_q)]    = 1'b1;
        acc                             = run ? (press & ~rev_mask) : 4'b0000;
        dir_d                           = dir_q;
        req_d                           = req_q;

        if (tick) begin
            if (req_q[0])      dir_d = DIR_RIGHT;
            else if (req_q[1]) dir_d = DIR_LEFT;
            else if (req_q[2]) dir_d = DIR_UP;
            else if (req_q[3]) dir_d = DIR_DOWN;
            req_d = 4'b0000;
        end

        if (acc[0])      req_d = 4'b0001;
        else if (acc[1]) req_d = 4'b0010;
        else if (acc[2]) req_d = 4'b0100;
        else if (acc[3]) req_d = 4'b1000;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tick_cnt_q <= '0;
            req_q      <= 4'b0000;
            dir_q      <= DIR_RIGHT;
        end else begin
            tick_cnt_q <= tick_cnt_d;
            req_q      <= req_d;
            dir_q      <= dir_d;
        end
    end

    assign right = req_q[0];
    assign left  = req_q[1];
    assign up    = req_q[2];
    assign down  = req_q[3];
    assign dir   = dir_q;

endmodule

// File: tb/tb_snake_input_conditioner.sv
// -----------------------------------------------------------------------------
// tb_snake_input_conditioner
// Directed bench for snake_input_conditioner with DEBOUNCE_CYCLES=4,
// TICK_DIV=8.  cyc counts rising clk edges since rst was last released, so
// the tick is expected whenever cyc mod 8 == 7.  Requests are compared as the
// vector {down, up, left, right}.
// -----------------------------------------------------------------------------
module tb_snake_input_conditioner;

    localparam int DB = 4;
    localparam int TD = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic       btn_up, btn_down, btn_left, btn_right;
    logic       tick, up, down, left, right;
    logic [1:0] dir;
`ifdef SNAKE_PAUSE_EN
    logic       btn_pause;
    logic       paused;
`endif

    int nvec = 0;
    int nerr = 0;
    int cyc  = 0;

    snake_input_conditioner #(
        .DEBOUNCE_CYCLES(DB),
        .TICK_DIV(TD),
        .CNT_W(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .btn_up(btn_up),
        .btn_down(btn_down),
        .btn_left(btn_left),
        .btn_right(btn_right),
`ifdef SNAKE_PAUSE_EN
        .btn_pause(btn_pause),
        .paused(paused),
`endif
        .tick(tick),
        .up(up),
        .down(down),
        .left(left),
        .right(right),
        .dir(dir)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] reqs();
        return {down, up, left, right};
    endfunction

    // One clock, sample 1 ns after the edge, check the tick phase.
    task automatic clk1();
        @(posedge clk);
        #1;
        cyc++;
        chk("tick", {3'b000, tick}, {3'b000, (cyc % TD) == TD - 1});
    endtask

    initial begin
        rst       = 1'b1;
        btn_up    = 1'b0;
        btn_down  = 1'b0;
        btn_left  = 1'b0;
        btn_right = 1'b0;
`ifdef SNAKE_PAUSE_EN
        btn_pause = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req", reqs(), 4'b0000);
        chk("rst_dir", {2'b00, dir}, 4'h0);
        chk("rst_tick", {3'b000, tick}, 4'h0);
        rst = 1'b0;
        cyc = 0;

        // Idle: ticks at cyc 7, 15; nothing requested, dir right
        repeat (16) begin
            clk1();
            chk("idle_req", reqs(), 4'b0000);
            chk("idle_dir", {2'b00, dir}, 4'h0);
        end

        // Left while moving right is a reversal: never requested
        btn_left = 1'b1;
        repeat (24) begin
            clk1();
            chk("rev_req", reqs(), 4'b0000);
            chk("rev_dir", {2'b00, dir}, 4'h0);
        end
        btn_left = 1'b0;
        repeat (8) clk1();                      // cyc 48

        // Clean up press: request 6 clk after the raw edge
        btn_up = 1'b1;
        repeat (5) begin
            clk1();
            chk("up_early", reqs(), 4'b0000);
        end
        clk1();                                 // cyc 54
        chk("up_at6", reqs(), 4'b0100);
        clk1();                                 // cyc 55, tick
        chk("up_at_tick", reqs(), 4'b0100);
        chk("up_dir_pre", {2'b00, dir}, 4'h0);
        clk1();                                 // cyc 56
        chk("up_dir_post", {2'b00, dir}, 4'h2);
        chk("up_cleared", reqs(), 4'b0000);
        repeat (2) clk1();
        btn_up = 1'b0;
        repeat (8) begin
            clk1();
            chk("up_release", reqs(), 4'b0000);
        end                                     // cyc 66

        // Bouncing up (2-clk runs) never qualifies, then a stable hold does
        for (int i = 0; i < 20; i++) begin
            btn_up = ((i / 2) % 2) == 0;
            clk1();
            chk("bounce_req", reqs(), 4'b0000);
        end
        btn_up = 1'b1;
        repeat (5) begin
            clk1();
            chk("bounce_early", reqs(), 4'b0000);
        end
        clk1();                                 // cyc 92
        chk("bounce_at6", reqs(), 4'b0100);
        btn_up = 1'b0;
        repeat (12) clk1();                     // cyc 104
        chk("bounce_dir", {2'b00, dir}, 4'h2);
        chk("bounce_clr", reqs(), 4'b0000);

        // Right and down together while moving up: right wins
        btn_right = 1'b1;
        btn_down  = 1'b1;
        repeat (5) begin
            clk1();
            chk("rd_early", reqs(), 4'b0000);
        end
        clk1();                                 // cyc 110
        chk("rd_at6", reqs(), 4'b0001);
        clk1();                                 // cyc 111, tick
        chk("rd_at_tick", reqs(), 4'b0001);
        clk1();                                 // cyc 112
        chk("rd_dir", {2'b00, dir}, 4'h0);
        chk("rd_clr", reqs(), 4'b0000);
        btn_right = 1'b0;
        btn_down  = 1'b0;
        repeat (8) clk1();                      // cyc 120

        // Down pending at tick count 5, then reset
        repeat (7) clk1();                      // cyc 127, tick cycle
        btn_down = 1'b1;
        repeat (5) begin
            clk1();
            chk("dn_early", reqs(), 4'b0000);
        end
        clk1();                                 // cyc 133, count 5
        chk("dn_pending", reqs(), 4'b1000);
        rst = 1'b1;
        #1;
        chk("mrst_req", reqs(), 4'b0000);
        chk("mrst_dir", {2'b00, dir}, 4'h0);
        chk("mrst_tick", {3'b000, tick}, 4'h0);
        repeat (2) @(posedge clk);
        #1;
        chk("mrst_hold", reqs(), 4'b0000);
        rst = 1'b0;
        cyc = 0;
        // Held down re-debounces from scratch; first tick at cyc 7
        repeat (5) begin
            clk1();
            chk("redb_early", reqs(), 4'b0000);
        end
        clk1();                                 // cyc 6
        chk("redb_at6", reqs(), 4'b1000);
        clk1();                                 // cyc 7, tick
        chk("redb_dir_pre", {2'b00, dir}, 4'h0);
        clk1();                                 // cyc 8
        chk("redb_dir_post", {2'b00, dir}, 4'h3);
        chk("redb_clr", reqs(), 4'b0000);
        btn_down = 1'b0;
        repeat (8) clk1();                      // cyc 16

        // Left and up together while moving down: left beats up
        btn_left = 1'b1;
        btn_up   = 1'b1;
        repeat (5) clk1();
        clk1();                                 // cyc 22
        chk("lu_at6", reqs(), 4'b0010);
        clk1();                                 // cyc 23, tick
        clk1();                                 // cyc 24
        chk("lu_dir", {2'b00, dir}, 4'h1);
        chk("lu_clr", reqs(), 4'b0000);
        btn_left = 1'b0;
        btn_up   = 1'b0;
        repeat (8) clk1();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
